// File: rtl/pipe_result_collector.sv
// Result collector for a fixed-latency pipeline: FIFO buffering,
// in-flight credit tracking and sticky protocol error flags.
module pipe_result_collector #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             credit_ok,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CW-1:0]    count,
  output logic             err_issue,
  output logic             err_unexp,
  output logic             err_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] SAT  = '1;
  localparam logic [CW:0]   LIM  = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    inflight;
  logic             full;
  logic             pop;
  logic             push;
  logic             dec;
  logic [CW:0]      used;

  assign full      = (count == FULL);
  assign pop       = out_valid & out_ready;
  assign push      = in_valid & (~full | pop);
  assign dec       = in_valid & ((inflight != '0) | issue);
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];

  // Registered state only: issue has no path into credit_ok.
  assign used      = {1'b0, count} + {1'b0, inflight};
  assign credit_ok = (used < LIM);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      inflight  <= '0;
      err_issue <= 1'b0;
      err_unexp <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);

      if (push & ~pop)
        count <= count + ONE;
      else if (pop & ~push)
        count <= count - ONE;

      // Matched issue/return in one cycle cancels out.
      if (issue & ~dec) begin
        if (inflight != SAT) inflight <= inflight + ONE;
      end else if (dec & ~issue) begin
        inflight <= inflight - ONE;
      end

      if (issue & ~credit_ok)
        err_issue <= 1'b1;
      if (in_valid & (inflight == '0) & ~issue)
        err_unexp <= 1'b1;
      if (in_valid & full & ~pop)
        err_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_result_collector.sv
// Bench for pipe_result_collector: table vectors, directed corner
// sequences and random traffic against a queue-based model.
module tb_pipe_result_collector;

  logic       clk = 0;
  logic       rst = 0;
  logic       issue = 0;
  logic       in_valid = 0;
  logic [9:0] in_data = '0;
  logic       credit_ok;
  logic       out_valid;
  logic [9:0] out_data;
  logic       out_ready = 0;
  logic [3:0] count;
  logic       err_issue;
  logic       err_unexp;
  logic       err_ovf;

  pipe_result_collector dut (
    .clk(clk), .rst(rst), .issue(issue),
    .in_valid(in_valid), .in_data(in_data),
    .credit_ok(credit_ok), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready),
    .count(count), .err_issue(err_issue),
    .err_unexp(err_unexp), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [9:0] q[$];
  int infl = 0;
  bit m_ei, m_eu, m_eo;

  logic [9:0] got[$];

  bit [2:0]   dl_v = '0;
  logic [9:0] dl_d [3];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit m_credit();
    return (q.size() + infl) < 8;
  endfunction

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1; issue = 0; in_valid = 0; out_ready = 0;
    repeat (n) @(posedge clk);
    #1;
    rst = 0;
    q.delete(); infl = 0;
    m_ei = 0; m_eu = 0; m_eo = 0;
    dl_v = '0;
  endtask

  // One cycle: drive, compare against model, advance model.
  task automatic step(input bit iss, input bit iv,
                      input logic [9:0] d, input bit rdy);
    bit pop;
    @(negedge clk);
    issue = iss; in_valid = iv; in_data = d; out_ready = rdy;
    #1;
    chk("out_valid", int'(out_valid), int'(q.size() > 0));
    if (q.size() > 0) chk("out_data", int'(out_data), int'(q[0]));
    chk("count", int'(count), q.size());
    chk("credit_ok", int'(credit_ok), int'(m_credit()));
    chk("err_issue", int'(err_issue), int'(m_ei));
    chk("err_unexp", int'(err_unexp), int'(m_eu));
    chk("err_ovf", int'(err_ovf), int'(m_eo));
    if (out_valid && rdy) got.push_back(out_data);
    pop = (q.size() > 0) && rdy;
    if (iss && !m_credit()) m_ei = 1;
    if (iv && infl == 0 && !iss) m_eu = 1;
    if (iv && q.size() == 8 && !pop) m_eo = 1;
    if (pop) void'(q.pop_front());
    if (iv && q.size() < 8) q.push_back(d);
    infl = infl + int'(iss) - int'(iv && (infl > 0 || iss));
    if (infl > 15) infl = 15;
    @(posedge clk);
  endtask

  // Cycle through a latency-3 pipeline model.
  task automatic cyc(input bit iss, input logic [9:0] d, input bit rdy);
    step(iss, dl_v[2], dl_d[2], rdy);
    dl_v = {dl_v[1:0], iss};
    dl_d[2] = dl_d[1]; dl_d[1] = dl_d[0]; dl_d[0] = d;
  endtask

  typedef struct {
    bit         iss;
    logic [9:0] d;
    bit         rdy;
    int         e_cnt;
    bit         e_vld;
    logic [9:0] e_dat;
    bit         e_crd;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acc, n, hits;
    bit iss;
    tbl[0] = '{1, 10'd10, 0, 0, 0, 10'd0, 1};
    tbl[1] = '{1, 10'd9,  0, 0, 0, 10'd0, 1};
    tbl[2] = '{1, 10'd16, 0, 0, 0, 10'd0, 1};
    tbl[3] = '{0, 10'd0,  0, 1, 1, 10'd10, 1};
    tbl[4] = '{0, 10'd0,  0, 2, 1, 10'd10, 1};
    tbl[5] = '{0, 10'd0,  0, 3, 1, 10'd10, 1};
    tbl[6] = '{0, 10'd0,  1, 2, 1, 10'd9, 1};
    tbl[7] = '{0, 10'd0,  1, 1, 1, 10'd16, 1};
    tbl[8] = '{0, 10'd0,  1, 0, 0, 10'd0, 1};

    // Reset and idle, then mid-stream reset.
    do_reset(2);
    chk("rst_count", int'(count), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_credit", int'(credit_ok), 1);
    chk("rst_errs", int'({err_issue, err_unexp, err_ovf}), 0);
    repeat (3) step(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 10'(i + 40), 0);
    #1 chk("pre_rst_count", int'(count), 3);
    do_reset(2);
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_valid", int'(out_valid), 0);

    // Table: three ops through the latency-3 pipeline.
    for (int i = 0; i < 9; i++) begin
      cyc(tbl[i].iss, tbl[i].d, tbl[i].rdy);
      #1;
      chk($sformatf("tbl%0d_count", i), int'(count), tbl[i].e_cnt);
      chk($sformatf("tbl%0d_valid", i), int'(out_valid), int'(tbl[i].e_vld));
      if (tbl[i].e_vld)
        chk($sformatf("tbl%0d_data", i), int'(out_data), int'(tbl[i].e_dat));
      chk($sformatf("tbl%0d_credit", i), int'(credit_ok), int'(tbl[i].e_crd));
    end

    // Credit limit.
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      iss = m_credit();
      if (iss) acc++;
      cyc(iss, 10'(i + 100), 0);
    end
    chk("credit_accepts", acc, 8);
    #1;
    chk("credit_full_count", int'(count), 8);
    chk("credit_zero", int'(credit_ok), 0);
    chk("credit_no_ovf", int'(err_ovf), 0);
    cyc(0, 0, 1);
    #1 chk("credit_after_pop", int'(credit_ok), 1);

    // Full buffer with simultaneous push and pop.
    cyc(1, 10'd200, 0);
    repeat (3) cyc(0, 0, 0);
    #1 chk("full_count", int'(count), 8);
    step(0, 1, 10'h3FF, 1);
    #1;
    chk("pushpop_count", int'(count), 8);
    chk("pushpop_no_ovf", int'(err_ovf), 0);
    got.delete();
    repeat (8) cyc(0, 0, 1);
    chk("pushpop_n", got.size(), 8);
    if (got.size() == 8) chk("pushpop_8th", int'(got[7]), 10'h3FF);

    // Issue without credit.
    do_reset(1);
    repeat (8) step(1, 0, 0, 0);
    #1 chk("noc_credit", int'(credit_ok), 0);
    step(1, 0, 0, 0);
    #1 chk("err_issue_set", int'(err_issue), 1);
    step(0, 0, 0, 0);
    #1 chk("err_issue_sticky", int'(err_issue), 1);

    // Unexpected result.
    do_reset(1);
    step(0, 1, 10'd5, 0);
    #1 chk("err_unexp_set", int'(err_unexp), 1);

    // Overflow drop.
    do_reset(1);
    for (int i = 0; i < 8; i++) step(0, 1, 10'(i + 1), 0);
    step(0, 1, 10'h155, 0);
    #1;
    chk("ovf_set", int'(err_ovf), 1);
    chk("ovf_count", int'(count), 8);
    got.delete();
    repeat (9) step(0, 0, 0, 1);
    hits = 0;
    foreach (got[i]) if (got[i] == 10'h155) hits++;
    chk("ovf_n", got.size(), 8);
    chk("ovf_dropped_absent", hits, 0);

    // Wrap-around stream with toggling ready.
    do_reset(1);
    got.delete();
    n = 0;
    for (int c = 0; c < 200 && got.size() < 20; c++) begin
      iss = (n < 20) && m_credit();
      cyc(iss, 10'(n), (c % 2) == 0);
      if (iss) n++;
    end
    chk("wrap_n", got.size(), 20);
    for (int i = 0; i < 20; i++)
      if (i < got.size()) chk($sformatf("wrap%0d", i), int'(got[i]), i);

    // Random traffic, including occasional credit violations.
    do_reset(1);
    for (int c = 0; c < 600; c++) begin
      if (m_credit()) iss = ($urandom_range(0, 2) != 0);
      else iss = ($urandom_range(0, 30) == 0);
      cyc(iss, 10'($urandom), $urandom_range(0, 1) == 1);
    end
    repeat (20) cyc(0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
